// File: rtl/fft_modulus_calc.sv
// fft_modulus_calc: squares complex FFT beats into |X|^2, tags them with bin/frame flags
// and writes the words into the spectrum FIFO under arm/continuous capture control.
module fft_modulus_calc #(
  parameter int IN_W = 30,
  parameter int IDX_W = 11,
  parameter int FRAME_LEN = 2048
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fft_valid,
  input  logic                        fft_last,
  input  logic signed [IN_W-1:0]      fft_re,
  input  logic signed [IN_W-1:0]      fft_im,
  output logic                        fft_ready,
  input  logic                        arm,
  input  logic                        cont,
  input  logic                        fifo_almost_full,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [2*IN_W+IDX_W+1:0]     fifo_wr_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic [15:0]                 drop_cnt
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_SOF = 2'd1, CAPTURE = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  logic [1:0] state;
  logic [IDX_W-1:0] idx;
  logic acc, at_last, frame_end, cap, out_cap;
  logic signed [IN_W-1:0] re1, im1;
  logic signed [2*IN_W-1:0] re_sq, im_sq;
  logic [2*IN_W-1:0] mag;
  logic [IDX_W+1:0] tag1, tag2, tag3;
  logic cap1, cap2, cap3;
  always_comb begin
    fft_ready = rst ? 1'b0 : (state == CAPTURE) ? ~fifo_almost_full : 1'b1;
    acc = fft_valid & fft_ready;
    at_last = idx == LAST_IDX;
    frame_end = fft_last | at_last;
    cap = (state == CAPTURE) | ((state == WAIT_SOF) & (idx == '0));
    out_cap = cap3 & ~rst;
    fifo_wr_en = out_cap & ~fifo_full;
    frame_done = out_cap & tag3[IDX_W];
    fifo_wr_data = {tag3, mag};
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      frame_err <= 1'b0;
      drop_cnt <= '0;
      cap1 <= 1'b0;
      cap2 <= 1'b0;
      cap3 <= 1'b0;
      re1 <= '0;
      im1 <= '0;
      re_sq <= '0;
      im_sq <= '0;
      mag <= '0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
    end else begin
      if (acc) idx <= frame_end ? '0 : idx + 1'b1;
      if (acc && (fft_last != at_last)) frame_err <= 1'b1;
      if (cap3 && fifo_full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      // arm clears the status of the previous capture, overriding any same-edge update
      if (state == IDLE && arm) begin
        state <= WAIT_SOF;
        frame_err <= 1'b0;
        drop_cnt <= '0;
      end else if (acc && cap) begin
        state <= (frame_end && !cont) ? IDLE : CAPTURE;
      end
      cap1 <= acc & cap;
      re1 <= fft_re;
      im1 <= fft_im;
      tag1 <= {idx == '0, frame_end, idx};
      cap2 <= cap1;
      re_sq <= re1 * re1;
      im_sq <= im1 * im1;
      tag2 <= tag1;
      cap3 <= cap2;
      mag <= re_sq + im_sq;
      tag3 <= tag2;
    end
  end
endmodule

// File: tb/tb_fft_modulus_calc.sv
// tb_fft_modulus_calc: directed and randomized checks of fft_modulus_calc against a
// cycle-level behavioural model of capture, tagging, latency and status counters.
module tb_fft_modulus_calc;
  localparam int IN_W = 30, IDX_W = 11, FL = 8, MW = 2 * IN_W, W = MW + IDX_W + 2;
  localparam logic signed [IN_W-1:0] MINV = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [IN_W-1:0] MAXV = {1'b0, {(IN_W-1){1'b1}}};
  logic clk = 0, rst = 1, fft_valid = 0, fft_last = 0, arm = 0, cont = 0;
  logic fifo_almost_full = 0, fifo_full = 0;
  logic signed [IN_W-1:0] fft_re = 0, fft_im = 0;
  logic fft_ready, fifo_wr_en, busy, frame_done, frame_err;
  logic [W-1:0] fifo_wr_data;
  logic [15:0] drop_cnt;
  int checks = 0, errors = 0;
  int m_mode = 0, m_idx = 0, m_drop = 0, done_cnt = 0, rdy_low = 0;
  bit m_err = 0;
  bit d_cap[3];
  logic [W-1:0] d_dat[3];
  logic [W-1:0] wlog[$];

  always #5 clk = ~clk;

  fft_modulus_calc #(.IN_W(IN_W), .IDX_W(IDX_W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_last(fft_last),
    .fft_re(fft_re), .fft_im(fft_im), .fft_ready(fft_ready), .arm(arm), .cont(cont),
    .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // model: modes 0 idle, 1 waiting for bin 0, 2 capturing; d_* is the 3-cycle latency line
  always @(negedge clk) begin
    bit rdy, acc, lb, fe, cp;
    logic [W-1:0] e_dat;
    longint r, i;
    rdy = !rst && !(m_mode == 2 && fifo_almost_full);
    chk("fft_ready", fft_ready, rdy);
    chk("busy", busy, m_mode != 0);
    chk("frame_err", frame_err, m_err);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("fifo_wr_en", fifo_wr_en, !rst && d_cap[2] && !fifo_full);
    chk("frame_done", frame_done, !rst && d_cap[2] && d_dat[2][W-2]);
    if (!rst && d_cap[2] && !fifo_full) chk("fifo_wr_data", fifo_wr_data, d_dat[2]);
    if (fifo_wr_en) wlog.push_back(fifo_wr_data);
    if (frame_done) done_cnt++;
    if (!rst && !fft_ready) rdy_low++;
    acc = 0;
    cp = 0;
    fe = 0;
    e_dat = '0;
    if (rst) begin
      m_mode = 0;
      m_idx = 0;
      m_err = 0;
      m_drop = 0;
      d_cap = '{default: 0};
    end else begin
      acc = fft_valid && rdy;
      if (d_cap[2] && fifo_full && m_drop < 65535) m_drop++;
      if (acc) begin
        lb = m_idx == FL - 1;
        fe = fft_last || lb;
        if (fft_last != lb) m_err = 1;
        cp = m_mode == 2 || (m_mode == 1 && m_idx == 0);
        r = fft_re;
        i = fft_im;
        e_dat = {1'(m_idx == 0), fe, IDX_W'(m_idx), MW'(r * r + i * i)};
        m_idx = fe ? 0 : m_idx + 1;
      end
      if (m_mode == 0 && arm) begin
        m_mode = 1;
        m_err = 0;
        m_drop = 0;
      end else if (acc && cp) m_mode = (fe && !cont) ? 0 : 2;
      d_cap[2] = d_cap[1];
      d_dat[2] = d_dat[1];
      d_cap[1] = d_cap[0];
      d_dat[1] = d_dat[0];
      d_cap[0] = acc && cp;
      d_dat[0] = e_dat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [IN_W-1:0] re, input logic signed [IN_W-1:0] im, input bit last);
    int n;
    fft_valid = 1;
    fft_re = re;
    fft_im = im;
    fft_last = last;
    #1;
    n = 0;
    while (!fft_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n == 50) begin
      errors++;
      $display("FAIL send timeout: fft_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fft_valid = 0;
    fft_last = 0;
    repeat (n) tick();
  endtask

  task automatic pulse_arm();
    fft_valid = 0;
    arm = 1;
    tick();
    arm = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) tick();
    chk("rst fft_ready", fft_ready, 0);
    chk("rst fifo_wr_en", fifo_wr_en, 0);
    chk("rst fifo_wr_data", fifo_wr_data, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    rst = 0;
    tick();
    // single capture of one frame out of two
    wlog.delete();
    done_cnt = 0;
    pulse_arm();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FL; i++) send(3, -4, i == FL - 1);
    idle(6);
    chk("t1 writes", wlog.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1 word", wlog[i], {1'(i == 0), 1'(i == 7), IDX_W'(i), MW'(25)});
    chk("t1 frame_done", done_cnt, 1);
    chk("t1 busy", busy, 0);
    // extreme operands
    wlog.delete();
    pulse_arm();
    send(MINV, MINV, 0);
    send(MAXV, 0, 0);
    send(0, 0, 0);
    for (int i = 3; i < FL; i++) send(IN_W'($urandom), IN_W'($urandom), i == FL - 1);
    idle(6);
    chk("t2 writes", wlog.size(), 8);
    chk("t2 min sq", wlog[0][MW-1:0], 60'h800000000000000);
    chk("t2 max sq", wlog[1][MW-1:0], 60'h3FFFFFFC0000001);
    chk("t2 zero", wlog[2][MW-1:0], 0);
    // arm mid-frame
    wlog.delete();
    for (int i = 0; i < 3; i++) send(1, 1, 0);
    arm = 1;
    send(5, 5, 0);
    arm = 0;
    for (int i = 4; i < FL; i++) send(2, 2, i == FL - 1);
    for (int i = 0; i < FL; i++) send(IN_W'(i + 1), 0, i == FL - 1);
    idle(6);
    chk("t3 writes", wlog.size(), 8);
    chk("t3 first sof", wlog[0][W-1], 1);
    chk("t3 first idx", wlog[0][MW+:IDX_W], 0);
    chk("t3 first mag", wlog[0][MW-1:0], 1);
    chk("t3 last mag", wlog[7][MW-1:0], 64);
    // backpressure during capture
    wlog.delete();
    pulse_arm();
    rdy_low = 0;
    fork
      for (int i = 0; i < FL; i++) send(IN_W'(i), IN_W'(i), i == FL - 1);
      begin
        repeat (3) tick();
        fifo_almost_full = 1;
        repeat (5) tick();
        fifo_almost_full = 0;
      end
    join
    idle(6);
    chk("t4 ready low cycles", rdy_low, 5);
    chk("t4 writes", wlog.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4 word", wlog[i], {1'(i == 0), 1'(i == 7), IDX_W'(i), MW'(2 * i * i)});
    // fifo_full drops
    wlog.delete();
    done_cnt = 0;
    pulse_arm();
    fork
      for (int i = 0; i < FL; i++) send(7, 1, i == FL - 1);
      begin
        repeat (5) tick();
        fifo_full = 1;
        repeat (4) tick();
        fifo_full = 0;
      end
    join
    idle(6);
    chk("t5 writes", wlog.size(), 4);
    chk("t5 drop_cnt", drop_cnt, 4);
    chk("t5 kept idx", wlog[2][MW+:IDX_W], 6);
    chk("t5 frame_done", done_cnt, 1);
    pulse_arm();
    chk("t5 drop cleared", drop_cnt, 0);
    for (int i = 0; i < FL; i++) send(1, 0, i == FL - 1);
    idle(6);
    // short frame in continuous mode, then reset mid-frame
    wlog.delete();
    cont = 1;
    pulse_arm();
    for (int i = 0; i < FL; i++) send(1, 2, i == FL - 1);
    for (int i = 0; i < 6; i++) send(2, 1, i == 5);
    chk("t6 frame_err", frame_err, 1);
    for (int i = 0; i < FL; i++) send(3, 3, i == FL - 1);
    idle(6);
    chk("t6 writes", wlog.size(), 22);
    chk("t6 short eof", wlog[13][W-2:MW], {1'b1, IDX_W'(5)});
    chk("t6 next sof", wlog[14][W-1:MW], {2'b10, IDX_W'(0)});
    chk("t6 busy", busy, 1);
    for (int i = 0; i < 3; i++) send(4, 4, 0);
    rst = 1;
    fft_valid = 0;
    n0 = wlog.size();
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t6 rst no write", fifo_wr_en, 0);
      tick();
    end
    chk("t6 rst busy", busy, 0);
    chk("t6 rst frame_err", frame_err, 0);
    chk("t6 rst fifo_wr_data", fifo_wr_data, 0);
    chk("t6 rst drop_cnt", drop_cnt, 0);
    rst = 0;
    cont = 0;
    tick();
    chk("t6 no writes after rst", wlog.size(), n0);
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      arm = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 499) == 0) cont = ~cont;
      fft_valid = $urandom_range(0, 3) != 0;
      fft_last = $urandom_range(0, 11) == 0;
      fifo_almost_full = $urandom_range(0, 7) == 0;
      fifo_full = $urandom_range(0, 9) == 0;
      fft_re = IN_W'($urandom);
      fft_im = IN_W'($urandom);
      tick();
    end
    rst = 0;
    arm = 0;
    fifo_full = 0;
    fifo_almost_full = 0;
    idle(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
